edge_timestamper: RTL and testbench

- Downstream consumer of the signal shifter's delayed output_signal.
- Arms a capture window on start and timestamps every selected edge of its input relative to window start.
- Buffers timestamps in an internal FIFO drained through a valid/ready pop port, which the AXI command bridge will read back.
- Single clock, same domain as the shifter; no CDC inside.

---
 rtl/edge_timestamper_if.sv | 21 ++
 rtl/edge_timestamper.sv | 163 ++++++++++++++++
 tb/tb_edge_timestamper.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_timestamper_if.sv
// Timestamp pop port: show-ahead FIFO head offered by the timestamper and drained by a consumer.
// ts_data is {polarity (1 = rising), timestamp}.
interface edge_timestamper_if #(
    parameter int TIME_WIDTH = 32
);
    logic [TIME_WIDTH:0] ts_data;
    logic                ts_valid;
    logic                ts_ready;

    modport master (
        output ts_data,
        output ts_valid,
        input  ts_ready
    );

    modport slave (
        input  ts_data,
        input  ts_valid,
        output ts_ready
    );
endinterface

// File: rtl/edge_timestamper.sv
// Arms a capture window on start, timestamps selected edges of input_signal relative to window start,
// and buffers {polarity, timestamp} entries in a show-ahead FIFO drained through the pop interface.
module edge_timestamper #(
    parameter int TIME_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TIME_WIDTH-1:0]  window_len,
    input  logic [1:0]             edge_mode,
    input  logic                   input_signal,
    edge_timestamper_if.master     ts_if,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] event_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    sig_q, prev_q;
    logic [TIME_WIDTH-1:0]   win_len_q, win_len_d;
    logic [1:0]              mode_q, mode_d;
    logic [TIME_WIDTH-1:0]   timer_q, timer_d;
    logic                    done_q, done_d;
    logic                    overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic [TIME_WIDTH:0]     mem_q [FIFO_DEPTH];
    logic [TIME_WIDTH:0]     mem_d [FIFO_DEPTH];

    logic rise, fall;
    logic fifo_empty, fifo_full;
    logic pop, push, edge_hit;
    logic in_capture, last_cycle;

    always_comb begin
        rise       = sig_q & ~prev_q;
        fall       = ~sig_q & prev_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = ~fifo_empty & ts_if.ts_ready;
        in_capture = (state_q == ST_CAPTURE);
        last_cycle = in_capture && (timer_q == win_len_q - TIME_WIDTH'(1));
        edge_hit   = in_capture & ((rise & mode_q[0]) | (fall & mode_q[1]));
        // A full FIFO still takes the edge when the head leaves in the same cycle.
        push       = edge_hit & (~fifo_full | pop);
    end

    always_comb begin
        state_d    = state_q;
        win_len_d  = win_len_q;
        mode_d     = mode_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = {rise, timer_q};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (edge_hit) begin
            if (count_q != '1) begin
                count_d = count_q + COUNT_WIDTH'(1);
            end
            if (!push) begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_CAPTURE: begin
                timer_d = timer_q + TIME_WIDTH'(1);
                if (last_cycle) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                // Arming discards everything left over from the previous window, including pending pops.
                if (start) begin
                    win_len_d  = window_len;
                    mode_d     = edge_mode;
                    timer_d    = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    if (window_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sig_q      <= 1'b0;
            prev_q     <= 1'b0;
            win_len_q  <= '0;
            mode_q     <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sig_q      <= input_signal;
            prev_q     <= sig_q;
            win_len_q  <= win_len_d;
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        busy           = in_capture;
        done           = done_q;
        overflow       = overflow_q;
        event_count    = count_q;
        ts_if.ts_valid = ~fifo_empty;
        ts_if.ts_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

endmodule

// File: tb/tb_edge_timestamper.sv
// Directed bench for edge_timestamper: capture windows, edge polarity selection, FIFO overflow,
// zero-length windows, ignored restarts and mid-window reset.
module tb_edge_timestamper;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] window_len;
    logic [1:0]  edge_mode;
    logic        input_signal;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] event_count;

    int tests_run;
    int tests_failed;
    int cyc;
    logic seen_done;

    edge_timestamper_if #(.TIME_WIDTH(32)) ts_if ();

    edge_timestamper #(
        .TIME_WIDTH (32),
        .FIFO_DEPTH (16),
        .COUNT_WIDTH(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .window_len  (window_len),
        .edge_mode   (edge_mode),
        .input_signal(input_signal),
        .ts_if       (ts_if.master),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so every sample sits clear of the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // After this returns the window timer reads 0 and cyc counts CAPTURE cycles.
    task automatic applyStimulus(input logic [31:0] wl, input logic [1:0] mode);
        start      = 1'b1;
        window_len = wl;
        edge_mode  = mode;
        tick();
        start = 1'b0;
        cyc   = 0;
    endtask

    // The level change is sampled at the edge that starts timer value t, so it is stamped t.
    task automatic drive_edge(input int t, input logic value);
        run_to(t - 1);
        input_signal = value;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] expected);
        checkOutput({tag, "_valid"}, 64'(ts_if.ts_valid), 64'd1);
        checkOutput(tag, 64'(ts_if.ts_data), expected);
        ts_if.ts_ready = 1'b1;
        tick();
        ts_if.ts_ready = 1'b0;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        cyc            = 0;
        reset          = 1'b1;
        start          = 1'b0;
        window_len     = '0;
        edge_mode      = '0;
        input_signal   = 1'b0;
        ts_if.ts_ready = 1'b0;

        tick();
        tick();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_valid", 64'(ts_if.ts_valid), 64'd0);
        checkOutput("rst_data", 64'(ts_if.ts_data), 64'd0);
        checkOutput("rst_count", 64'(event_count), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        tick();
        tick();

        // Rising only, window 100: rises at 10 and 40, fall at 20 is not selected.
        applyStimulus(32'd100, 2'b01);
        checkOutput("t1_busy0", 64'(busy), 64'd1);
        drive_edge(10, 1'b1);
        drive_edge(20, 1'b0);
        drive_edge(40, 1'b1);
        run_to(99);
        checkOutput("t1_done_early", 64'(done), 64'd0);
        checkOutput("t1_busy_last", 64'(busy), 64'd1);
        run_to(100);
        checkOutput("t1_done", 64'(done), 64'd1);
        checkOutput("t1_busy_done", 64'(busy), 64'd0);
        checkOutput("t1_count", 64'(event_count), 64'd2);
        tick();
        checkOutput("t1_done_once", 64'(done), 64'd0);
        pop_expect("t1_e0", 64'h1_0000_000A);
        pop_expect("t1_e1", 64'h1_0000_0028);
        checkOutput("t1_empty", 64'(ts_if.ts_valid), 64'd0);

        // Both polarities, same stimulus.
        input_signal = 1'b0;
        repeat (3) tick();
        applyStimulus(32'd100, 2'b11);
        drive_edge(10, 1'b1);
        drive_edge(20, 1'b0);
        drive_edge(40, 1'b1);
        run_to(100);
        checkOutput("t2_count", 64'(event_count), 64'd3);
        checkOutput("t2_ovf", 64'(overflow), 64'd0);
        tick();
        pop_expect("t2_e0", 64'h1_0000_000A);
        pop_expect("t2_e1", 64'h0_0000_0014);
        pop_expect("t2_e2", 64'h1_0000_0028);
        checkOutput("t2_empty", 64'(ts_if.ts_valid), 64'd0);

        // Twenty rises into a 16-deep FIFO with no consumer: first 16 kept.
        input_signal = 1'b0;
        repeat (3) tick();
        applyStimulus(32'd100, 2'b01);
        for (int i = 0; i < 20; i++) begin
            drive_edge(4 * i + 2, 1'b1);
            drive_edge(4 * i + 4, 1'b0);
        end
        run_to(100);
        checkOutput("t3_count", 64'(event_count), 64'd20);
        checkOutput("t3_ovf", 64'(overflow), 64'd1);
        tick();
        for (int i = 0; i < 16; i++) begin
            pop_expect($sformatf("t3_e%0d", i), 64'h1_0000_0000 | 64'(4 * i + 2));
        end
        checkOutput("t3_empty", 64'(ts_if.ts_valid), 64'd0);

        // FIFO full, consumer pops in the same cycle as the 17th edge: nothing dropped.
        applyStimulus(32'd100, 2'b01);
        for (int i = 0; i < 16; i++) begin
            drive_edge(4 * i + 2, 1'b1);
            drive_edge(4 * i + 4, 1'b0);
        end
        drive_edge(66, 1'b1);
        run_to(66);
        ts_if.ts_ready = 1'b1;
        tick();
        ts_if.ts_ready = 1'b0;
        drive_edge(68, 1'b0);
        run_to(100);
        checkOutput("t3b_ovf", 64'(overflow), 64'd0);
        checkOutput("t3b_count", 64'(event_count), 64'd17);
        tick();
        for (int i = 0; i < 16; i++) begin
            pop_expect($sformatf("t3b_e%0d", i), 64'h1_0000_0000 | 64'(4 * i + 6));
        end
        checkOutput("t3b_empty", 64'(ts_if.ts_valid), 64'd0);

        // Zero-length window.
        applyStimulus(32'd0, 2'b01);
        checkOutput("t4_done", 64'(done), 64'd1);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        checkOutput("t4_valid", 64'(ts_if.ts_valid), 64'd0);
        tick();
        checkOutput("t4_done_once", 64'(done), 64'd0);
        checkOutput("t4_busy_after", 64'(busy), 64'd0);

        // Start during CAPTURE with a shorter length is ignored.
        applyStimulus(32'd20, 2'b01);
        run_to(5);
        start      = 1'b1;
        window_len = 32'd5;
        tick();
        start = 1'b0;
        run_to(19);
        checkOutput("t4b_busy", 64'(busy), 64'd1);
        checkOutput("t4b_done_early", 64'(done), 64'd0);
        run_to(20);
        checkOutput("t4b_done", 64'(done), 64'd1);

        // Edge on the last window cycle kept, edge one cycle later ignored.
        tick();
        applyStimulus(32'd20, 2'b11);
        drive_edge(19, 1'b1);
        drive_edge(20, 1'b0);
        run_to(20);
        checkOutput("t5_done", 64'(done), 64'd1);
        run_to(22);
        checkOutput("t5_count", 64'(event_count), 64'd1);
        pop_expect("t5_e0", 64'h1_0000_0013);
        checkOutput("t5_empty", 64'(ts_if.ts_valid), 64'd0);

        // Overflowed window, then restart from DONE flushes FIFO and clears overflow.
        applyStimulus(32'd40, 2'b11);
        for (int i = 1; i <= 17; i++) begin
            drive_edge(i, 1'(i % 2));
        end
        run_to(40);
        checkOutput("t5b_ovf", 64'(overflow), 64'd1);
        checkOutput("t5b_count", 64'(event_count), 64'd17);
        checkOutput("t5b_valid", 64'(ts_if.ts_valid), 64'd1);
        applyStimulus(32'd30, 2'b01);
        checkOutput("t5b_flush", 64'(ts_if.ts_valid), 64'd0);
        checkOutput("t5b_ovf_clr", 64'(overflow), 64'd0);
        checkOutput("t5b_count_clr", 64'(event_count), 64'd0);
        run_to(30);
        checkOutput("t5b_done", 64'(done), 64'd1);
        input_signal = 1'b0;

        // Reset in the middle of a window.
        repeat (3) tick();
        applyStimulus(32'd100, 2'b01);
        drive_edge(10, 1'b1);
        run_to(50);
        checkOutput("t6_pre_count", 64'(event_count), 64'd1);
        reset = 1'b1;
        #2;
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_done", 64'(done), 64'd0);
        checkOutput("t6_valid", 64'(ts_if.ts_valid), 64'd0);
        checkOutput("t6_data", 64'(ts_if.ts_data), 64'd0);
        checkOutput("t6_count", 64'(event_count), 64'd0);
        checkOutput("t6_ovf", 64'(overflow), 64'd0);
        reset        = 1'b0;
        input_signal = 1'b0;
        seen_done    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        checkOutput("t6_no_done", 64'(seen_done), 64'd0);
        applyStimulus(32'd10, 2'b01);
        drive_edge(3, 1'b1);
        run_to(10);
        checkOutput("t6_new_done", 64'(done), 64'd1);
        checkOutput("t6_new_count", 64'(event_count), 64'd1);
        pop_expect("t6_e0", 64'h1_0000_0003);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
